// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte queue between the APB slave and the UART transmitter.
//
// The APB slave pushes bytes into a DEPTH-entry FIFO. A small FSM pops one byte
// at a time into the tx_data holding register and hands it to the transmitter
// with the tx_en / tx_busy / tx_done handshake.
//
// Ports
//   PCLK, PRESETn     clock, asynchronous active-low reset
//   wr_en, wr_data    push request and byte from the APB slave
//   flush             synchronous clear of FIFO storage (in-flight byte unaffected)
//   full, empty       storage status, decoded from the next count and registered
//   count             bytes held in storage, excluding the in-flight byte
//   overflow          one-cycle pulse after a dropped push
//   active            a byte is in flight (START or SEND)
//   tx_busy, tx_done  transmitter status: busy level, end-of-frame pulse
//   tx_en, tx_data    start request and byte presented to the transmitter
module uart_tx_fifo #(
  parameter int unsigned WIDTH8 = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              wr_en,
  input  logic [WIDTH8-1:0] wr_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              active,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic              tx_en,
  output logic [WIDTH8-1:0] tx_data
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SEND  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH8-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [WIDTH8-1:0] tx_data_q, tx_data_d;
  logic              full_q, empty_q;
  logic              overflow_q, overflow_d;
  logic              tx_en_q, active_q;

  logic              pop;
  logic              push_ok;

  // FSM next state; a pop happens only when leaving IDLE with data available
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty_q && !flush) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tx_busy) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop frees a slot, so a push while full is accepted with it
  always_comb begin
    push_ok    = wr_en && !flush && (!full_q || pop);
    overflow_d = wr_en && !flush && full_q && !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      tx_data_d = mem_q[rd_ptr_q];
    end

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge PCLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // State, pointers and registered outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_en_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      full_q     <= (count_d == DEPTH_CNT);
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
      tx_en_q    <= (state_d == S_START);
      active_q   <= (state_d != S_IDLE);
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign active   = active_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;

  logic       PCLK;
  logic       PRESETn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       active;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_en;
  logic [7:0] tx_data;

  // Transmitter handshake: manual drive or the auto model
  logic auto_mode;
  logic man_busy, man_done;
  logic mdl_busy, mdl_done;
  int   mdl_cnt;

  int n_chk;
  int n_bad;

  logic [7:0] got_q[$];
  int         gap_q[$];
  int         peak;

  assign tx_busy = auto_mode ? mdl_busy : man_busy;
  assign tx_done = auto_mode ? mdl_done : man_done;

  uart_tx_fifo #(.WIDTH8(8), .DEPTH(16), .AW(4)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .active   (active),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_en    (tx_en),
    .tx_data  (tx_data)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Transmitter model: busy for 10 cycles after seeing tx_en, done pulse at the end
  always @(posedge PCLK) begin
    if (!auto_mode) begin
      mdl_busy <= 1'b0;
      mdl_done <= 1'b0;
      mdl_cnt  <= 0;
    end else begin
      mdl_done <= 1'b0;
      if (mdl_cnt == 0) begin
        if (tx_en && !mdl_busy) begin
          mdl_busy <= 1'b1;
          mdl_cnt  <= 10;
        end
      end else begin
        if (mdl_cnt == 1) begin
          mdl_busy <= 1'b0;
          mdl_done <= 1'b1;
        end
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  // Run cycles, optionally pushing n_push bytes from base, logging each tx_en rise
  task automatic collect(input int n_frames, input int budget, input int n_push,
                         input logic [7:0] base);
    logic prev_en;
    int   since_done;
    got_q.delete();
    gap_q.delete();
    peak       = 0;
    prev_en    = tx_en;
    since_done = -1;
    for (int c = 0; c < budget && got_q.size() < n_frames; c++) begin
      if (c < n_push) begin
        wr_en   = 1'b1;
        wr_data = 8'(base + 8'(c));
      end else begin
        wr_en = 1'b0;
      end
      tick();
      if (int'(count) > peak) peak = int'(count);
      if (since_done >= 0) since_done++;
      if (tx_en && !prev_en) begin
        got_q.push_back(tx_data);
        if (since_done >= 0) gap_q.push_back(since_done);
        since_done = -1;
      end
      if (tx_done) since_done = 0;
      prev_en = tx_en;
    end
    wr_en = 1'b0;
    chk("frames_seen", 32'(got_q.size()), 32'(n_frames));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int c;
    c = 0;
    while (active && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(active), 0);
  endtask

  initial begin
    logic seen;
    n_chk     = 0;
    n_bad     = 0;
    auto_mode = 1'b0;
    man_busy  = 1'b0;
    man_done  = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    flush     = 1'b0;
    PRESETn   = 1'b1;

    // Reset values
    #2 PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_tx_en",    32'(tx_en),    0);
    chk("rst_tx_data",  32'(tx_data),  0);
    chk("rst_count",    32'(count),    0);
    chk("rst_empty",    32'(empty),    1);
    chk("rst_full",     32'(full),     0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_active",   32'(active),   0);
    PRESETn = 1'b1;
    tick();

    // Single byte 0xA5
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("t1_count1", 32'(count), 1);
    chk("t1_empty0", 32'(empty), 0);
    chk("t1_en_low", 32'(tx_en), 0);
    tick();
    chk("t1_en",     32'(tx_en),   1);
    chk("t1_data",   32'(tx_data), 32'h A5);
    chk("t1_count0", 32'(count),   0);
    chk("t1_active", 32'(active),  1);
    tick();
    tick();
    chk("t1_en_hold", 32'(tx_en), 1);
    man_busy = 1'b1;
    tick();
    chk("t1_send_en",  32'(tx_en),  0);
    chk("t1_send_act", 32'(active), 1);
    tick();
    tick();
    man_busy = 1'b0; man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("t1_idle_act", 32'(active),  0);
    chk("t1_empty",    32'(empty),   1);
    chk("t1_cnt_end",  32'(count),   0);
    chk("t1_data_kep", 32'(tx_data), 32'hA5);
    tick();
    chk("t1_quiet", 32'(tx_en), 0);

    // Burst 0x01..0x05 with the 10-cycle transmitter model
    auto_mode = 1'b1;
    collect(5, 200, 5, 8'h01);
    for (int i = 0; i < got_q.size(); i++) chk("t2_order", 32'(got_q[i]), 32'(i + 1));
    chk("t2_ngaps", 32'(gap_q.size()), 4);
    for (int i = 0; i < gap_q.size(); i++) chk("t2_gap", 32'(gap_q[i]), 2);
    chk("t2_peak", 32'(peak), 4);
    wait_idle("t2_idle", 50);
    chk("t2_empty", 32'(empty), 1);
    auto_mode = 1'b0;
    tick();

    // Fill while stuck in START, then overflow
    wr_en = 1'b1; wr_data = 8'h10;
    tick();
    wr_en = 1'b0;
    tick();
    chk("t3_en",   32'(tx_en),   1);
    chk("t3_data", 32'(tx_data), 32'h10);
    for (int i = 0; i < 17; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h20 + i);
      tick();
      if (i == 15) begin
        chk("t3_full",   32'(full),     1);
        chk("t3_cnt16",  32'(count),    16);
        chk("t3_no_ovf", 32'(overflow), 0);
      end
      if (i == 16) begin
        chk("t3_ovf",      32'(overflow), 1);
        chk("t3_ovf_cnt",  32'(count),    16);
        chk("t3_ovf_full", 32'(full),     1);
      end
    end
    wr_en = 1'b0;
    tick();
    chk("t3_ovf_pulse", 32'(overflow), 0);
    chk("t3_data_hold", 32'(tx_data),  32'h10);

    // Push while full coinciding with a pop
    man_busy = 1'b1;
    tick();
    man_busy = 1'b0; man_done = 1'b1;
    tick();
    man_done = 1'b0;
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    chk("t4_cnt",  32'(count),    16);
    chk("t4_ovf",  32'(overflow), 0);
    chk("t4_full", 32'(full),     1);
    chk("t4_en",   32'(tx_en),    1);
    chk("t4_data", 32'(tx_data),  32'h20);

    // Drain across the pointer wrap
    auto_mode = 1'b1;
    collect(16, 400, 0, 8'h00);
    for (int i = 0; i < got_q.size(); i++)
      chk("t4_drain", 32'(got_q[i]), (i < 15) ? 32'(8'h21 + i) : 32'h77);
    wait_idle("t4_idle", 50);
    chk("t4_cnt0",  32'(count), 0);
    chk("t4_empty", 32'(empty), 1);
    auto_mode = 1'b0;
    tick();

    // Flush during SEND with 3 bytes queued
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h41 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("t5_cnt3", 32'(count),   3);
    chk("t5_data", 32'(tx_data), 32'h41);
    man_busy = 1'b1;
    tick();
    chk("t5_send", 32'(tx_en), 0);
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h55;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk("t5_fl_cnt",   32'(count),    0);
    chk("t5_fl_empty", 32'(empty),    1);
    chk("t5_fl_ovf",   32'(overflow), 0);
    chk("t5_fl_act",   32'(active),   1);
    tick();
    chk("t5_drop_cnt", 32'(count),    0);
    chk("t5_drop_ovf", 32'(overflow), 0);
    man_busy = 1'b0; man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("t5_done_act", 32'(active), 0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_en) seen = 1'b1;
    end
    chk("t5_no_en",   32'(seen),    0);
    chk("t5_data_kp", 32'(tx_data), 32'h41);

    // Asynchronous reset while in START
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h66 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("t6_en",  32'(tx_en), 1);
    chk("t6_cnt", 32'(count), 2);
    #2 PRESETn = 1'b0;
    #1;
    chk("t6_rst_en",    32'(tx_en),   0);
    chk("t6_rst_data",  32'(tx_data), 0);
    chk("t6_rst_cnt",   32'(count),   0);
    chk("t6_rst_act",   32'(active),  0);
    chk("t6_rst_empty", 32'(empty),   1);
    @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'h99;
    tick();
    wr_en = 1'b0;
    chk("t6_post_cnt", 32'(count), 1);
    tick();
    chk("t6_post_en",   32'(tx_en),   1);
    chk("t6_post_data", 32'(tx_data), 32'h99);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
